// File: rtl/pwf_pkg.sv
// rtl/pwf_pkg.sv - shared state/mode types and counter-width helper for the pulse-width filter
package pwf_pkg;

   typedef enum logic [1:0] {LOW, QUAL_HI, HIGH, QUAL_LO} pwf_state_t;

   typedef enum logic {PWF_LEVEL, PWF_ONESHOT} pwf_mode_t;

   // Wide enough to hold max(MIN_HI, MIN_LO) itself.
   function automatic int cnt_w(input int min_hi, input int min_lo);
      int m;
      m = (min_hi > min_lo) ? min_hi : min_lo;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pwf_ch.sv
// rtl/pwf_ch.sv - one pulse-width filter channel: hysteresis FSM, qualify counter, level/one-shot output
// Optional width accumulator and capture under PWF_WIDTH_CAPTURE_EN.
module pwf_ch
   import pwf_pkg::*;
#(
   parameter int MIN_HI  = 4,
   parameter int MIN_LO  = 4,
   parameter int WIDTH_W = 16
) (
   input  logic               clk11m,
   input  logic               rst_n,
   input  logic               g,
   input  logic               mode,
`ifdef PWF_WIDTH_CAPTURE_EN
   output logic [WIDTH_W-1:0] width,
   output logic               width_vld,
`endif
   output logic               i
);

   localparam int CNT_W = cnt_w(MIN_HI, MIN_LO);
   localparam logic [CNT_W-1:0] HI_N = CNT_W'(MIN_HI);
   localparam logic [CNT_W-1:0] LO_N = CNT_W'(MIN_LO);

   if (MIN_HI < 1 || MIN_LO < 1 || WIDTH_W < 1) begin : g_bad_param
      $error("pwf_ch: MIN_HI, MIN_LO and WIDTH_W must all be at least 1");
   end

   pwf_state_t       state;
   pwf_state_t       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic             i_nx;
   pwf_mode_t        mode_e;

   assign mode_e  = pwf_mode_t'(mode);
   assign cnt_inc = cnt + CNT_W'(1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         LOW: begin
            if (g) begin
               if (MIN_HI == 1) begin
                  state_nx = HIGH;
               end else begin
                  state_nx = QUAL_HI;
                  cnt_nx   = CNT_W'(1);
               end
            end
         end
         QUAL_HI: begin
            if (!g) begin
               state_nx = LOW;
               cnt_nx   = '0;
            end else if (cnt_inc == HI_N) begin
               state_nx = HIGH;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt_inc;
            end
         end
         HIGH: begin
            if (!g) begin
               if (MIN_LO == 1) begin
                  state_nx = LOW;
               end else begin
                  state_nx = QUAL_LO;
                  cnt_nx   = CNT_W'(1);
               end
            end
         end
         QUAL_LO: begin
            if (g) begin
               state_nx = HIGH;
               cnt_nx   = '0;
            end else if (cnt_inc == LO_N) begin
               state_nx = LOW;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt_inc;
            end
         end
         default: begin
            state_nx = LOW;
            cnt_nx   = '0;
         end
      endcase
   end

   // A return from QUAL_LO is not a new pulse, so one-shot keys on the source state.
   always_comb begin
      i_nx = 1'b0;
      if (mode_e == PWF_ONESHOT) begin
         i_nx = (state_nx == HIGH) && (state == LOW || state == QUAL_HI);
      end else begin
         i_nx = (state_nx == HIGH) || (state_nx == QUAL_LO);
      end
   end

`ifdef PWF_WIDTH_CAPTURE_EN
   localparam logic [WIDTH_W-1:0] ACC_MAX = '1;

   logic [WIDTH_W-1:0] acc;
   logic [WIDTH_W-1:0] acc_nx;
   logic [WIDTH_W-1:0] width_nx;
   logic               vld_nx;

   always_comb begin
      acc_nx   = acc;
      width_nx = width;
      vld_nx   = 1'b0;
      if (state_nx == LOW) begin
         acc_nx = '0;
         if (state == HIGH || state == QUAL_LO) begin
            width_nx = acc;
            vld_nx   = 1'b1;
         end
      end else if (g && acc != ACC_MAX) begin
         acc_nx = acc + WIDTH_W'(1);
      end
   end
`endif

   always_ff @(posedge clk11m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOW;
         cnt       <= '0;
         i         <= 1'b0;
`ifdef PWF_WIDTH_CAPTURE_EN
         acc       <= '0;
         width     <= '0;
         width_vld <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         i         <= i_nx;
`ifdef PWF_WIDTH_CAPTURE_EN
         acc       <= acc_nx;
         width     <= width_nx;
         width_vld <= vld_nx;
`endif
      end
   end

endmodule

// File: rtl/pwf_multi.sv
// rtl/pwf_multi.sv - N_CH independent pulse-width filter channels sharing one mode input
// Width capture ports exist only under PWF_WIDTH_CAPTURE_EN.
module pwf_multi
   import pwf_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int MIN_HI  = 4,
   parameter int MIN_LO  = 4,
   parameter int WIDTH_W = 16
) (
   input  logic                      clk11m,
   input  logic                      rst_n,
   input  logic [N_CH-1:0]           g,
   input  logic                      mode,
`ifdef PWF_WIDTH_CAPTURE_EN
   output logic [N_CH*WIDTH_W-1:0]   width,
   output logic [N_CH-1:0]           width_vld,
`endif
   output logic [N_CH-1:0]           i
);

   if (N_CH < 1) begin : g_bad_param
      $error("pwf_multi: N_CH must be at least 1");
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      pwf_ch #(
         .MIN_HI  (MIN_HI),
         .MIN_LO  (MIN_LO),
         .WIDTH_W (WIDTH_W)
      ) u_ch (
         .clk11m    (clk11m),
         .rst_n     (rst_n),
         .g         (g[c]),
         .mode      (mode),
`ifdef PWF_WIDTH_CAPTURE_EN
         .width     (width[c*WIDTH_W +: WIDTH_W]),
         .width_vld (width_vld[c]),
`endif
         .i         (i[c])
      );
   end

endmodule

// File: tb/tb_pwf_multi.sv
// tb/tb_pwf_multi.sv - self-checking bench for pwf_multi: directed vector table plus randomized run against a run-length model
// Width checks are compiled in with PWF_WIDTH_CAPTURE_EN.
module tb_pwf_multi;

   localparam int N_CH    = 2;
   localparam int MIN_HI  = 4;
   localparam int MIN_LO  = 3;
   localparam int WIDTH_W = 16;

   logic        clk11m = 1'b0;
   logic        rst_n  = 1'b0;
   logic [1:0]  g      = 2'b00;
   logic        mode   = 1'b0;
   logic [1:0]  i;
`ifdef PWF_WIDTH_CAPTURE_EN
   logic [31:0] width;
   logic [1:0]  width_vld;
`endif

   pwf_multi #(
      .N_CH    (N_CH),
      .MIN_HI  (MIN_HI),
      .MIN_LO  (MIN_LO),
      .WIDTH_W (WIDTH_W)
   ) dut (
      .clk11m    (clk11m),
      .rst_n     (rst_n),
      .g         (g),
      .mode      (mode),
`ifdef PWF_WIDTH_CAPTURE_EN
      .width     (width),
      .width_vld (width_vld),
`endif
      .i         (i)
   );

   always #5 clk11m = ~clk11m;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  g;
      logic        mode;
      logic [1:0]  ei;
      logic [1:0]  ev;
      logic [15:0] ew0;
      logic [15:0] ew1;
   } vec_t;

   vec_t vecs[$];

   task automatic push(input logic [1:0] gv, input logic m, input logic [1:0] ei,
                       input logic [1:0] ev, input logic [15:0] w0, input logic [15:0] w1);
      vec_t v;
      v.g = gv; v.mode = m; v.ei = ei; v.ev = ev; v.ew0 = w0; v.ew1 = w1;
      vecs.push_back(v);
   endtask

   // Reference: filtered level flips once the current run of opposite samples is long enough.
   bit filt [2];
   int rh   [2];
   int rl   [2];
   int acc  [2];
   int cap_w[2];

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         filt[c] = 1'b0; rh[c] = 0; rl[c] = 0; acc[c] = 0; cap_w[c] = 0;
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v < 65535) ? v + 1 : v;
   endfunction

   task automatic model_step(input logic [1:0] gv, input logic m,
                             output logic [1:0] ei, output logic [1:0] ev);
      ei = 2'b00;
      ev = 2'b00;
      for (int c = 0; c < 2; c++) begin
         logic rose;
         rose = 1'b0;
         if (gv[c]) begin
            rh[c]++; rl[c] = 0;
         end else begin
            rl[c]++; rh[c] = 0;
         end
         if (!filt[c]) begin
            acc[c] = gv[c] ? sat_inc(acc[c]) : 0;
            if (rh[c] >= MIN_HI) begin
               filt[c] = 1'b1;
               rose    = 1'b1;
            end
         end else begin
            if (gv[c]) acc[c] = sat_inc(acc[c]);
            if (rl[c] >= MIN_LO) begin
               filt[c]  = 1'b0;
               cap_w[c] = acc[c];
               acc[c]   = 0;
               ev[c]    = 1'b1;
            end
         end
         ei[c] = m ? rose : filt[c];
      end
   endtask

   initial begin
      logic [1:0] gr;
      logic       mr;
      logic [1:0] ei;
      logic [1:0] ev;
      int         run_left[2];

      // Reset, then async reset while i[0] is high.
      repeat (3) @(posedge clk11m);
      @(negedge clk11m);
      rst_n = 1'b1;
      @(posedge clk11m); #1;
      check("reset_i", 32'(i), 32'(2'b00));
`ifdef PWF_WIDTH_CAPTURE_EN
      check("reset_width", width, 32'h0);
      check("reset_vld", 32'(width_vld), 32'h0);
`endif
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk11m); g = 2'b01;
         @(posedge clk11m); #1;
      end
      check("pre_reset_i", 32'(i), 32'(2'b01));
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_i", 32'(i), 32'(2'b00));
`ifdef PWF_WIDTH_CAPTURE_EN
      check("async_reset_vld", 32'(width_vld), 32'h0);
`endif
      @(negedge clk11m); g = 2'b00;
      @(posedge clk11m); #1;
      check("in_reset_i", 32'(i), 32'(2'b00));
      @(negedge clk11m); rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk11m); #1;
         check("post_reset_i", 32'(i), 32'(2'b00));
      end

      // Level accept: 14 highs on ch0.
      for (int k = 1; k <= 14; k++) push(2'b01, 1'b0, (k >= 4) ? 2'b01 : 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b01, 16'd14, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      // Glitch reject, then accept on 4 highs.
      for (int k = 1; k <= 3; k++) push(2'b01, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      for (int k = 1; k <= 4; k++) push(2'b01, 1'b0, (k == 4) ? 2'b01 : 2'b00, 2'b00, 16'd0, 16'd0);
      // Low dip absorbed, then release: 4+1+2 highs.
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      for (int k = 1; k <= 3; k++) push(2'b01, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b01, 16'd7, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      // Mode switches while in HIGH.
      for (int k = 1; k <= 5; k++) push(2'b01, 1'b0, (k >= 4) ? 2'b01 : 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b01, 1'b1, 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b01, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b01, 16'd7, 16'd0);
      push(2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
      // One-shot on ch1 with a single-cycle dip at cycle 6.
      for (int k = 1; k <= 10; k++) push((k != 6) ? 2'b10 : 2'b00, 1'b1, (k == 4) ? 2'b10 : 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b1, 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b1, 2'b00, 2'b00, 16'd0, 16'd0);
      push(2'b00, 1'b1, 2'b00, 2'b10, 16'd0, 16'd9);
      push(2'b00, 1'b1, 2'b00, 2'b00, 16'd0, 16'd0);

      foreach (vecs[n]) begin
         @(negedge clk11m);
         g    = vecs[n].g;
         mode = vecs[n].mode;
         @(posedge clk11m); #1;
         check($sformatf("vec%0d_i", n), 32'(i), 32'(vecs[n].ei));
`ifdef PWF_WIDTH_CAPTURE_EN
         check($sformatf("vec%0d_vld", n), 32'(width_vld), 32'(vecs[n].ev));
         if (vecs[n].ev[0]) check($sformatf("vec%0d_width0", n), 32'(width[15:0]), 32'(vecs[n].ew0));
         if (vecs[n].ev[1]) check($sformatf("vec%0d_width1", n), 32'(width[31:16]), 32'(vecs[n].ew1));
`endif
      end

      // Randomized runs against the model.
      @(negedge clk11m);
      rst_n = 1'b0;
      g     = 2'b00;
      mode  = 1'b0;
      @(negedge clk11m);
      rst_n = 1'b1;
      model_reset();
      gr = 2'b00;
      mr = 1'b0;
      run_left[0] = 0;
      run_left[1] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < 2; c++) begin
            if (run_left[c] == 0) begin
               gr[c]       = ~gr[c];
               run_left[c] = int'($urandom_range(1, 7));
            end
            run_left[c]--;
         end
         if ($urandom_range(0, 39) == 0) mr = ~mr;
         @(negedge clk11m);
         g    = gr;
         mode = mr;
         model_step(gr, mr, ei, ev);
         @(posedge clk11m); #1;
         check("rand_i", 32'(i), 32'(ei));
`ifdef PWF_WIDTH_CAPTURE_EN
         check("rand_vld", 32'(width_vld), 32'(ev));
         check("rand_width", width, {16'(cap_w[1]), 16'(cap_w[0])});
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
